// File: rtl/instr_decoder_if.sv
// Instruction-in / decoded-fields-out bundle between fetch and the dispatch decoder.
// The master side drives the instruction; the slave side (the decoder) returns the fields.
interface instr_decoder_if;
   logic        valid_in;
   logic [31:0] instr;
   logic        valid_out;
   logic        is_ls;
   logic        is_jump;
   logic [5:0]  optype;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] imm;

   modport master (
      output valid_in, instr,
      input  valid_out, is_ls, is_jump, optype, rd, rs1, rs2, imm
   );

   modport slave (
      input  valid_in, instr,
      output valid_out, is_ls, is_jump, optype, rd, rs1, rs2, imm
   );
endinterface

// File: rtl/instr_decoder.sv
// Registered RV32I decoder: classifies one instruction into an internal optype,
// extracts register indices and the immediate, and flags loads/stores and branches.
module instr_decoder (
   input logic            clk,
   input logic            rst,
   input logic            rdy,
   instr_decoder_if.slave dec
);

   typedef enum logic [5:0] {
      OpNop   = 6'd0,  OpLui  = 6'd1,  OpAuipc = 6'd2,  OpJal  = 6'd3,  OpJalr = 6'd4,
      OpBeq   = 6'd5,  OpBne  = 6'd6,  OpBlt   = 6'd7,  OpBge  = 6'd8,  OpBltu = 6'd9,
      OpBgeu  = 6'd10, OpLb   = 6'd11, OpLh    = 6'd12, OpLw   = 6'd13, OpLbu  = 6'd14,
      OpLhu   = 6'd15, OpSb   = 6'd16, OpSh    = 6'd17, OpSw   = 6'd18, OpAddi = 6'd19,
      OpSlti  = 6'd20, OpSltiu = 6'd21, OpXori = 6'd22, OpOri  = 6'd23, OpAndi = 6'd24,
      OpSlli  = 6'd25, OpSrli = 6'd26, OpSrai  = 6'd27, OpAdd  = 6'd28, OpSub  = 6'd29,
      OpSll   = 6'd30, OpSlt  = 6'd31, OpSltu  = 6'd32, OpXor  = 6'd33, OpSrl  = 6'd34,
      OpSra   = 6'd35, OpOr   = 6'd36, OpAnd   = 6'd37
   } op_e;

   typedef enum logic [2:0] {FmtNone, FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ} fmt_e;

   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        alt;

   op_e         op_d;
   fmt_e        fmt;
   logic        is_shift;
   logic        is_ls_d, is_jump_d;
   logic [4:0]  rd_d, rs1_d, rs2_d;
   logic [31:0] imm_d;

   logic        valid_q, is_ls_q, is_jump_q;
   logic [5:0]  optype_q;
   logic [4:0]  rd_q, rs1_q, rs2_q;
   logic [31:0] imm_q;

   assign instr  = dec.instr;
   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign alt    = instr[30];

   // Classify into optype and instruction format; FmtNone marks anything undefined.
   always_comb begin
      op_d     = OpNop;
      fmt      = FmtNone;
      is_shift = 1'b0;
      case (opcode)
         7'b0110111: begin op_d = OpLui;   fmt = FmtU; end
         7'b0010111: begin op_d = OpAuipc; fmt = FmtU; end
         7'b1101111: begin op_d = OpJal;   fmt = FmtJ; end
         7'b1100111: if (funct3 == 3'b000) begin op_d = OpJalr; fmt = FmtI; end
         7'b1100011: begin
            fmt = FmtB;
            case (funct3)
               3'b000:  op_d = OpBeq;
               3'b001:  op_d = OpBne;
               3'b100:  op_d = OpBlt;
               3'b101:  op_d = OpBge;
               3'b110:  op_d = OpBltu;
               3'b111:  op_d = OpBgeu;
               default: fmt  = FmtNone;
            endcase
         end
         7'b0000011: begin
            fmt = FmtI;
            case (funct3)
               3'b000:  op_d = OpLb;
               3'b001:  op_d = OpLh;
               3'b010:  op_d = OpLw;
               3'b100:  op_d = OpLbu;
               3'b101:  op_d = OpLhu;
               default: fmt  = FmtNone;
            endcase
         end
         7'b0100011: begin
            fmt = FmtS;
            case (funct3)
               3'b000:  op_d = OpSb;
               3'b001:  op_d = OpSh;
               3'b010:  op_d = OpSw;
               default: fmt  = FmtNone;
            endcase
         end
         7'b0010011: begin
            fmt = FmtI;
            case (funct3)
               3'b000:  op_d = OpAddi;
               3'b010:  op_d = OpSlti;
               3'b011:  op_d = OpSltiu;
               3'b100:  op_d = OpXori;
               3'b110:  op_d = OpOri;
               3'b111:  op_d = OpAndi;
               3'b001:  begin op_d = OpSlli; is_shift = 1'b1; end
               default: begin op_d = alt ? OpSrai : OpSrli; is_shift = 1'b1; end
            endcase
         end
         7'b0110011: begin
            fmt = FmtR;
            case (funct3)
               3'b000:  op_d = alt ? OpSub : OpAdd;
               3'b001:  op_d = OpSll;
               3'b010:  op_d = OpSlt;
               3'b011:  op_d = OpSltu;
               3'b100:  op_d = OpXor;
               3'b101:  op_d = alt ? OpSra : OpSrl;
               3'b110:  op_d = OpOr;
               default: op_d = OpAnd;
            endcase
         end
         default: ;
      endcase
      if (fmt == FmtNone) begin
         op_d     = OpNop;
         is_shift = 1'b0;
      end
   end

   // Field extraction driven purely by the format.
   always_comb begin
      rd_d  = 5'd0;
      rs1_d = 5'd0;
      rs2_d = 5'd0;
      imm_d = 32'd0;
      if (fmt inside {FmtR, FmtI, FmtU, FmtJ}) rd_d  = instr[11:7];
      if (fmt inside {FmtR, FmtI, FmtS, FmtB}) rs1_d = instr[19:15];
      if (fmt inside {FmtR, FmtS, FmtB})       rs2_d = instr[24:20];
      case (fmt)
         FmtI:    imm_d = is_shift ? {27'd0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
         FmtS:    imm_d = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FmtB:    imm_d = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         FmtU:    imm_d = {instr[31:12], 12'd0};
         FmtJ:    imm_d = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21],
                           1'b0};
         default: imm_d = 32'd0;
      endcase
   end

   assign is_ls_d   = (op_d >= OpLb)  && (op_d <= OpSw);
   assign is_jump_d = (op_d >= OpBeq) && (op_d <= OpBgeu);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         is_ls_q   <= 1'b0;
         is_jump_q <= 1'b0;
         optype_q  <= 6'd0;
         rd_q      <= 5'd0;
         rs1_q     <= 5'd0;
         rs2_q     <= 5'd0;
         imm_q     <= 32'd0;
      end else if (rdy) begin
         valid_q   <= dec.valid_in;
         is_ls_q   <= is_ls_d;
         is_jump_q <= is_jump_d;
         optype_q  <= op_d;
         rd_q      <= rd_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         imm_q     <= imm_d;
      end
   end

   assign dec.valid_out = valid_q;
   assign dec.is_ls     = is_ls_q;
   assign dec.is_jump   = is_jump_q;
   assign dec.optype    = optype_q;
   assign dec.rd        = rd_q;
   assign dec.rs1       = rs1_q;
   assign dec.rs2       = rs2_q;
   assign dec.imm       = imm_q;

endmodule

// File: tb/tb_instr_decoder.sv
// Bench for instr_decoder: directed instructions plus random ones, checked against
// a table-driven reference decoder and a model of the output register.
module tb_instr_decoder;

   typedef struct packed {
      logic        v;
      logic        ls;
      logic        jmp;
      logic [5:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } dec_t;

   logic clk = 1'b0;
   logic rst;
   logic rdy;
   int   checks = 0;
   int   failures = 0;
   dec_t exp_q;

   instr_decoder_if bus ();

   instr_decoder dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .dec (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] sext(input int unsigned val, input int bits);
      longint v = longint'(val);
      if (val >= (32'd1 << (bits - 1))) v = v - (longint'(1) << bits);
      return 32'(v);
   endfunction

   // Reference decoder: funct3-indexed tables per opcode class, -1 marks undefined.
   function automatic dec_t ref_decode(input logic [31:0] in, input logic vin);
      dec_t        d;
      int          op;
      byte         fmt;
      int          tab[8];
      int unsigned f3;
      int unsigned w;
      w   = in;
      f3  = (w >> 12) & 7;
      op  = -1;
      fmt = "-";
      case (w & 32'h7f)
         32'h37: begin op = 1; fmt = "U"; end
         32'h17: begin op = 2; fmt = "U"; end
         32'h6f: begin op = 3; fmt = "J"; end
         32'h67: begin op = (f3 == 0) ? 4 : -1; fmt = "I"; end
         32'h63: begin tab = '{5, 6, -1, -1, 7, 8, 9, 10}; op = tab[f3]; fmt = "B"; end
         32'h03: begin tab = '{11, 12, 13, -1, 14, 15, -1, -1}; op = tab[f3]; fmt = "I"; end
         32'h23: begin tab = '{16, 17, 18, -1, -1, -1, -1, -1}; op = tab[f3]; fmt = "S"; end
         32'h13: begin
            tab = '{19, 25, 20, 21, 22, 26, 23, 24};
            op = tab[f3];
            if (op == 26 && in[30]) op = 27;
            fmt = "I";
         end
         32'h33: begin
            tab = '{28, 30, 31, 32, 33, 34, 36, 37};
            op = tab[f3];
            if ((op == 28 || op == 34) && in[30]) op = op + 1;
            fmt = "R";
         end
         default: op = -1;
      endcase
      d   = '0;
      d.v = vin;
      if (op < 0) return d;
      d.op  = 6'(op);
      d.ls  = (op >= 11 && op <= 18);
      d.jmp = (op >= 5 && op <= 10);
      if (fmt == "U" || fmt == "J" || fmt == "I" || fmt == "R") d.rd = 5'((w >> 7) & 31);
      if (fmt == "I" || fmt == "S" || fmt == "B" || fmt == "R") d.rs1 = 5'((w >> 15) & 31);
      if (fmt == "S" || fmt == "B" || fmt == "R") d.rs2 = 5'((w >> 20) & 31);
      if (op >= 25 && op <= 27)  d.imm = (w >> 20) & 31;
      else if (fmt == "I")       d.imm = sext(w >> 20, 12);
      else if (fmt == "S")       d.imm = sext(((w >> 25) << 5) | ((w >> 7) & 31), 12);
      else if (fmt == "B")       d.imm = sext(((w >> 31) << 12) | (((w >> 7) & 1) << 11) |
                                              (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1),
                                              13);
      else if (fmt == "U")       d.imm = w & 32'hfffff000;
      else if (fmt == "J")       d.imm = sext(((w >> 31) << 20) | (((w >> 12) & 255) << 12) |
                                              (((w >> 20) & 1) << 11) |
                                              (((w >> 21) & 1023) << 1), 21);
      return d;
   endfunction

   // One clock: advance the register model, then compare every output against it.
   task automatic tick(input string tag);
      @(posedge clk);
      #1;
      if (rst)      exp_q = '0;
      else if (rdy) exp_q = ref_decode(bus.instr, bus.valid_in);
      check_val({tag, ".valid_out"}, 32'(bus.valid_out), 32'(exp_q.v));
      check_val({tag, ".is_ls"},     32'(bus.is_ls),     32'(exp_q.ls));
      check_val({tag, ".is_jump"},   32'(bus.is_jump),   32'(exp_q.jmp));
      check_val({tag, ".optype"},    32'(bus.optype),    32'(exp_q.op));
      check_val({tag, ".rd"},        32'(bus.rd),        32'(exp_q.rd));
      check_val({tag, ".rs1"},       32'(bus.rs1),       32'(exp_q.rs1));
      check_val({tag, ".rs2"},       32'(bus.rs2),       32'(exp_q.rs2));
      check_val({tag, ".imm"},       bus.imm,            exp_q.imm);
   endtask

   task automatic drive(input logic r, input logic y, input logic v, input logic [31:0] w);
      rst          = r;
      rdy          = y;
      bus.valid_in = v;
      bus.instr    = w;
   endtask

   logic [6:0] opcodes[9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

   initial begin
      logic [31:0] w;
      int          k;
      exp_q = '0;
      drive(1'b1, 1'b1, 1'b1, 32'hFFF10093);
      tick("reset");
      check_val("reset_valid", 32'(bus.valid_out), 32'd0);

      drive(1'b0, 1'b1, 1'b1, 32'hFFF10093);
      tick("addi");
      check_val("addi_op", 32'(bus.optype), 32'd19);
      check_val("addi_imm", bus.imm, 32'hFFFFFFFF);

      drive(1'b0, 1'b1, 1'b1, 32'h00512423);
      tick("sw");
      check_val("sw_op", 32'(bus.optype), 32'd18);
      check_val("sw_imm", bus.imm, 32'h8);

      drive(1'b0, 1'b1, 1'b1, 32'hFE208EE3);
      tick("beq");
      check_val("beq_op", 32'(bus.optype), 32'd5);
      check_val("beq_imm", bus.imm, 32'hFFFFFFFC);

      drive(1'b0, 1'b1, 1'b1, 32'h123451B7);
      tick("lui");
      check_val("lui_imm", bus.imm, 32'h12345000);

      drive(1'b0, 1'b1, 1'b1, 32'h40325213);
      tick("srai");
      check_val("srai_op", 32'(bus.optype), 32'd27);
      check_val("srai_imm", bus.imm, 32'd3);

      drive(1'b0, 1'b1, 1'b1, 32'hFFFFFFFF);
      tick("illegal");
      check_val("illegal_valid", 32'(bus.valid_out), 32'd1);

      drive(1'b0, 1'b1, 1'b1, 32'h00512423);
      tick("sw2");
      drive(1'b0, 1'b0, 1'b0, 32'hFE208EE3);
      tick("hold1");
      drive(1'b0, 1'b0, 1'b1, 32'h123451B7);
      tick("hold2");
      check_val("hold_op", 32'(bus.optype), 32'd18);

      drive(1'b1, 1'b0, 1'b1, 32'h123451B7);
      tick("rst_nordy");
      check_val("rst_nordy_valid", 32'(bus.valid_out), 32'd0);

      // valid_in low still registers the decoded fields.
      drive(1'b0, 1'b1, 1'b0, 32'h40325213);
      tick("novalid");
      check_val("novalid_op", 32'(bus.optype), 32'd27);

      for (int i = 0; i < 600; i++) begin
         w = $urandom;
         k = $urandom_range(0, 9);
         if (k < 9) w[6:0] = opcodes[k];
         drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 9) != 0),
               1'($urandom_range(0, 1)), w);
         tick("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
